// File: rtl/collector_uart_tx.sv
// Sample FIFO feeding a UART packet transmitter: 0xA5 header, FRAME_LEN payload bytes, 8-bit payload sum.
// Define COLLECTOR_UART_TX_PARITY_EN to insert an even-parity bit before every stop bit (11-bit frames).
module collector_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned FRAME_LEN    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       tx,
   output logic       busy,
   output logic       pkt_done
);

   localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef COLLECTOR_UART_TX_PARITY_EN
   localparam int unsigned LAST_BIT = 10;
`else
   localparam int unsigned LAST_BIT = 9;
`endif
   localparam logic [7:0] HDR_BYTE = 8'hA5;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;

   state_t             state, state_n;
   logic               ser_active, ser_active_n;
   logic [3:0]         bit_idx, bit_idx_n, nxt_idx;
   logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
   logic [7:0]         shift, shift_n;
   logic               tx_q, tx_n;
   logic [7:0]         chk, chk_n;
   logic [7:0]         pay_cnt, pay_cnt_n;
   logic               done_q, done_n;
   logic               busy_q;
   logic               bit_end, byte_end, pay_try, load;
   logic [7:0]         load_val;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [COUNT_W-1:0] count, count_n;
   logic               ready_q, ready_n;
   logic               push, pop, fifo_empty;
   logic [7:0]         head;

   assign push       = s_valid && ready_q;
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];

   // FIFO occupancy; ready is registered from the next count so it never depends on s_valid combinationally
   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + COUNT_W'(1);
         2'b01:   count_n = count - COUNT_W'(1);
         default: count_n = count;
      endcase
      ready_n = (count_n < COUNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   // Packet sequencing and bit serialiser next-state
   always_comb begin
      state_n      = state;
      ser_active_n = ser_active;
      bit_idx_n    = bit_idx;
      clk_cnt_n    = clk_cnt;
      shift_n      = shift;
      tx_n         = tx_q;
      chk_n        = chk;
      pay_cnt_n    = pay_cnt;
      done_n       = 1'b0;
      pop          = 1'b0;
      load         = 1'b0;
      load_val     = HDR_BYTE;
      pay_try      = 1'b0;
      nxt_idx      = bit_idx + 4'd1;
      bit_end      = ser_active && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
      byte_end     = bit_end && (bit_idx == 4'(LAST_BIT));

      if (ser_active) begin
         if (!bit_end) begin
            clk_cnt_n = clk_cnt + CNT_W'(1);
         end else begin
            clk_cnt_n = '0;
            if (byte_end) begin
               ser_active_n = 1'b0;
               tx_n         = 1'b1;
            end else begin
               bit_idx_n = nxt_idx;
               if (nxt_idx <= 4'd8) tx_n = shift[3'(nxt_idx - 4'd1)];
`ifdef COLLECTOR_UART_TX_PARITY_EN
               else if (nxt_idx == 4'd9) tx_n = ^shift;
`endif
               else tx_n = 1'b1;
            end
         end
      end

      case (state)
         S_IDLE: begin
            if (!fifo_empty) state_n = S_HDR;
         end
         S_HDR: begin
            if (!ser_active) begin
               load = 1'b1;
            end else if (byte_end) begin
               state_n = S_PAY;
               pay_try = 1'b1;
            end
         end
         S_PAY: begin
            // serialiser free: either idle on underrun or finishing the previous stop bit
            if (!ser_active || byte_end) begin
               if (pay_cnt == 8'(FRAME_LEN)) begin
                  state_n  = S_CHK;
                  load     = 1'b1;
                  load_val = chk;
               end else begin
                  pay_try = 1'b1;
               end
            end
         end
         S_CHK: begin
            if (byte_end) begin
               state_n   = S_IDLE;
               done_n    = 1'b1;
               chk_n     = '0;
               pay_cnt_n = '0;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (pay_try && !fifo_empty) begin
         load      = 1'b1;
         load_val  = head;
         pop       = 1'b1;
         chk_n     = chk + head;
         pay_cnt_n = pay_cnt + 8'd1;
      end

      if (load) begin
         ser_active_n = 1'b1;
         bit_idx_n    = '0;
         clk_cnt_n    = '0;
         shift_n      = load_val;
         tx_n         = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ser_active <= 1'b0;
         bit_idx    <= '0;
         clk_cnt    <= '0;
         shift      <= '0;
         tx_q       <= 1'b1;
         chk        <= '0;
         pay_cnt    <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ready_q    <= 1'b1;
      end else begin
         state      <= state_n;
         ser_active <= ser_active_n;
         bit_idx    <= bit_idx_n;
         clk_cnt    <= clk_cnt_n;
         shift      <= shift_n;
         tx_q       <= tx_n;
         chk        <= chk_n;
         pay_cnt    <= pay_cnt_n;
         done_q     <= done_n;
         busy_q     <= (state_n != S_IDLE);
         count      <= count_n;
         ready_q    <= ready_n;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   assign tx       = tx_q;
   assign s_ready  = ready_q;
   assign busy     = busy_q;
   assign pkt_done = done_q;

endmodule

// File: tb/tb_collector_uart_tx.sv
// Bench for collector_uart_tx: a UART line decoder and packet model check the serial output and handshake.
module tb_collector_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FLEN  = 2;
`ifdef COLLECTOR_UART_TX_PARITY_EN
   localparam int FBITS = 11;
`else
   localparam int FBITS = 10;
`endif
   localparam int FCYC = FBITS * CPB;
   localparam int TMO  = 20000;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic [7:0] s_data  = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_ready, tx, busy, pkt_done;

   collector_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .tx(tx), .busy(busy), .pkt_done(pkt_done)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0, pushes = 0, pops = 0, frame_idx = 0;
   int mon_s = -1, mon_glitch = 0;
   int done_cnt = 0, done_busy_err = 0, ready_err = 0, ready_low = 0;
   int last_push_edge = 0, fill = 0;
   logic [7:0]  sum = 8'h00;
   logic [10:0] mon_bits = '1;
   logic        mon_ok;
   logic [7:0]  exp_q[$], rx_q[$];
   logic        ok_q[$], par_q[$];
   int          start_q[$], done_edge_q[$];

   // Edge counter and accepted-sample count (pre-edge values)
   always @(posedge clk) begin
      if (rst === 1'b1) pushes = 0;
      else if (s_valid === 1'b1 && s_ready === 1'b1) pushes++;
      cyc++;
   end

   // Line decoder: every bit must hold for CPB samples; payload start bits are FIFO pops
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         mon_s = -1; frame_idx = 0; pops = 0;
      end else begin
         if (mon_s < 0 && tx === 1'b0) begin
            mon_s = 0; mon_glitch = 0;
            start_q.push_back(cyc);
            if ((frame_idx % (FLEN + 2)) != 0 && (frame_idx % (FLEN + 2)) <= FLEN) pops++;
         end
         if (mon_s >= 0) begin
            if (mon_s % CPB == 0) mon_bits[mon_s / CPB] = tx;
            else if (tx !== mon_bits[mon_s / CPB]) mon_glitch++;
            mon_s++;
            if (mon_s == FCYC) begin
               mon_ok = (mon_glitch == 0) && (mon_bits[0] == 1'b0) && (mon_bits[FBITS-1] == 1'b1);
`ifdef COLLECTOR_UART_TX_PARITY_EN
               mon_ok = mon_ok && (mon_bits[9] == ^mon_bits[8:1]);
`endif
               rx_q.push_back(mon_bits[8:1]);
               ok_q.push_back(mon_ok);
               par_q.push_back(mon_bits[9]);
               frame_idx++;
               mon_s = -1;
            end
         end
         if (pkt_done === 1'b1) begin
            done_cnt++; done_edge_q.push_back(cyc);
            if (busy !== 1'b0) done_busy_err++;
         end
         if (s_ready === 1'b0) ready_low++;
         if (s_ready !== ((pushes - pops) < DEPTH)) ready_err++;
      end
   end

   // Packet model: header, FLEN payload bytes, then their sum mod 256
   task automatic model_push(input logic [7:0] d);
      if (fill == 0) exp_q.push_back(8'hA5);
      exp_q.push_back(d);
      sum = sum + d;
      fill++;
      if (fill == FLEN) begin
         exp_q.push_back(sum);
         fill = 0; sum = 8'h00;
      end
   endtask

   task automatic push(input logic [7:0] d);
      int n = 0;
      s_data = d; s_valid = 1'b1;
      while (s_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
      checks++;
      if (n >= TMO) begin failures++; $display("FAIL push_timeout s_ready=%b exp=1", s_ready); end
      @(negedge clk);
      last_push_edge = cyc;
      model_push(d);
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end
      while ((rx_q.size() < exp_q.size() || busy !== 1'b0) && n < TMO);
      repeat (3) @(negedge clk);
      checks++;
      if (n >= TMO) begin
         failures++;
         $display("FAIL %s_timeout frames=%0d exp=%0d busy=%b", name, rx_q.size(), exp_q.size(), busy);
      end
   endtask

   function automatic int first_bad(input int base);
      int n = (rx_q.size() > exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = base; i < n; i++)
         if (i >= rx_q.size() || i >= exp_q.size() || rx_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] rx_at(input int i);
      return (i >= 0 && i < rx_q.size()) ? rx_q[i] : 8'hxx;
   endfunction

   function automatic logic [7:0] exp_at(input int i);
      return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'hxx;
   endfunction

   function automatic int bad_frames(input int base);
      int n = 0;
      for (int i = base; i < ok_q.size(); i++) if (ok_q[i] !== 1'b1) n++;
      return n;
   endfunction

   task automatic test_reset();
      int bad = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1)       begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
      checks++; if (s_ready !== 1'b1)  begin failures++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (pkt_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", pkt_done); end
      rst = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || pkt_done !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL idle_hold bad_cycles=%0d exp=0", bad); end
   endtask

   task automatic test_basic();
      int base = rx_q.size(), sb = start_q.size(), db = done_cnt, dq = done_edge_q.size();
      int e0, bad, gaps = 0;
      push(8'h12); e0 = last_push_edge;
      push(8'h34);
      wait_idle("basic");
      checks++;
      if (start_q.size() <= sb || start_q[sb] !== e0 + 2) begin
         failures++; $display("FAIL basic_latency got=%0d exp=%0d", (start_q.size() > sb) ? start_q[sb] - e0 : -1, 2);
      end
      bad = first_bad(base); checks++;
      if (bad !== -1) begin failures++; $display("FAIL basic_stream idx=%0d got=%02h exp=%02h", bad, rx_at(bad), exp_at(bad)); end
      checks++;
      if (rx_at(base + 3) !== 8'h46) begin failures++; $display("FAIL basic_checksum got=%02h exp=46", rx_at(base + 3)); end
      for (int i = 1; i < 4; i++)
         if (start_q.size() < sb + 4 || start_q[sb + i] - start_q[sb + i - 1] != FCYC) gaps++;
      checks++; if (gaps !== 0) begin failures++; $display("FAIL basic_back_to_back bad_gaps=%0d exp=0", gaps); end
      checks++;
      if (bad_frames(base) !== 0) begin failures++; $display("FAIL basic_framing bad=%0d exp=0", bad_frames(base)); end
      checks++;
      if (done_cnt - db !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - db); end
      checks++;
      if (done_edge_q.size() <= dq || start_q.size() < sb + 4 || done_edge_q[dq] !== start_q[sb + 3] + FCYC) begin
         failures++; $display("FAIL basic_done_time got=%0d exp=%0d",
            (done_edge_q.size() > dq) ? done_edge_q[dq] : -1, (start_q.size() >= sb + 4) ? start_q[sb + 3] + FCYC : -1);
      end
      checks++;
      if (done_busy_err !== 0) begin failures++; $display("FAIL basic_busy_at_done got=%0d exp=0", done_busy_err); end
   endtask

   task automatic test_wrap();
      int base = rx_q.size(), bad;
      push(8'hFF); push(8'h02);
      wait_idle("wrap");
      bad = first_bad(base); checks++;
      if (bad !== -1) begin failures++; $display("FAIL wrap_stream idx=%0d got=%02h exp=%02h", bad, rx_at(bad), exp_at(bad)); end
      checks++;
      if (rx_at(base + 3) !== 8'h01) begin failures++; $display("FAIL wrap_checksum got=%02h exp=01", rx_at(base + 3)); end
   endtask

   task automatic test_parity();
      int base = rx_q.size(), bad;
      push(8'h07); push(8'h01);
      wait_idle("parity");
      bad = first_bad(base); checks++;
      if (bad !== -1) begin failures++; $display("FAIL parity_stream idx=%0d got=%02h exp=%02h", bad, rx_at(bad), exp_at(bad)); end
      checks++;
      if (rx_at(base + 3) !== 8'h08) begin failures++; $display("FAIL parity_checksum got=%02h exp=08", rx_at(base + 3)); end
      checks++;
      if (bad_frames(base) !== 0) begin failures++; $display("FAIL parity_framing bad=%0d exp=0", bad_frames(base)); end
`ifdef COLLECTOR_UART_TX_PARITY_EN
      begin
         logic exp_par [4];
         exp_par = '{1'b0, 1'b1, 1'b1, 1'b1};
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (base + i >= par_q.size() || par_q[base + i] !== exp_par[i]) begin
               failures++;
               $display("FAIL parity_bit frame=%0d got=%b exp=%b", i, (base + i < par_q.size()) ? par_q[base + i] : 1'bx, exp_par[i]);
            end
         end
      end
`endif
   endtask

   task automatic test_fifo_full();
      int base = rx_q.size(), db = done_cnt, rl = ready_low, re = ready_err, bad;
      for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
      wait_idle("fifo_full");
      checks++;
      if (ready_low - rl <= 0) begin failures++; $display("FAIL fifo_ready_drop low_cycles=%0d exp>0", ready_low - rl); end
      checks++;
      if (ready_err - re !== 0) begin failures++; $display("FAIL fifo_ready_track bad_cycles=%0d exp=0", ready_err - re); end
      bad = first_bad(base); checks++;
      if (bad !== -1) begin failures++; $display("FAIL fifo_stream idx=%0d got=%02h exp=%02h", bad, rx_at(bad), exp_at(bad)); end
      checks++;
      if (done_cnt - db !== 3) begin failures++; $display("FAIL fifo_done_count got=%0d exp=3", done_cnt - db); end
   endtask

   task automatic test_underrun();
      int base = rx_q.size(), db = done_cnt, bad;
      push(8'($urandom_range(0, 255)));
      repeat (200) @(negedge clk);
      checks++;
      if (rx_q.size() - base !== 2) begin failures++; $display("FAIL underrun_frames got=%0d exp=2", rx_q.size() - base); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL underrun_busy got=%b exp=1", busy); end
      checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL underrun_tx got=%b exp=1", tx); end
      checks++;
      if (done_cnt - db !== 0) begin failures++; $display("FAIL underrun_early_done got=%0d exp=0", done_cnt - db); end
      push(8'($urandom_range(0, 255)));
      wait_idle("underrun");
      bad = first_bad(base); checks++;
      if (bad !== -1) begin failures++; $display("FAIL underrun_stream idx=%0d got=%02h exp=%02h", bad, rx_at(bad), exp_at(bad)); end
      checks++;
      if (done_cnt - db !== 1) begin failures++; $display("FAIL underrun_done_count got=%0d exp=1", done_cnt - db); end
   endtask

   task automatic test_reset_mid();
      int base = rx_q.size(), n = 0, bad, idle_bad = 0;
      push(8'($urandom_range(0, 255)));
      push(8'($urandom_range(0, 255)));
      while (rx_q.size() <= base && n < TMO) begin @(negedge clk); n++; end
      repeat (3 * CPB) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1)      begin failures++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", s_ready); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      while (exp_q.size() > rx_q.size()) void'(exp_q.pop_back());
      fill = 0; sum = 8'h00;
      base = rx_q.size();
      repeat (20) begin @(negedge clk); if (busy !== 1'b0 || tx !== 1'b1) idle_bad++; end
      checks++;
      if (idle_bad !== 0) begin failures++; $display("FAIL rstmid_fifo_empty bad_cycles=%0d exp=0", idle_bad); end
      push(8'($urandom_range(0, 255)));
      push(8'($urandom_range(0, 255)));
      wait_idle("rstmid");
      checks++;
      if (rx_at(base) !== 8'hA5) begin failures++; $display("FAIL rstmid_header got=%02h exp=a5", rx_at(base)); end
      bad = first_bad(base); checks++;
      if (bad !== -1) begin failures++; $display("FAIL rstmid_stream idx=%0d got=%02h exp=%02h", bad, rx_at(bad), exp_at(bad)); end
   endtask

   task automatic test_random();
      int base = rx_q.size(), db = done_cnt, bad;
      for (int i = 0; i < 3 * FLEN; i++) begin
         push(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      wait_idle("random");
      bad = first_bad(base); checks++;
      if (bad !== -1) begin failures++; $display("FAIL random_stream idx=%0d got=%02h exp=%02h", bad, rx_at(bad), exp_at(bad)); end
      checks++;
      if (bad_frames(base) !== 0) begin failures++; $display("FAIL random_framing bad=%0d exp=0", bad_frames(base)); end
      checks++;
      if (done_cnt - db !== 3) begin failures++; $display("FAIL random_done_count got=%0d exp=3", done_cnt - db); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_parity();
      test_fifo_full();
      test_underrun();
      test_reset_mid();
      test_random();
      checks++;
      if (ready_err !== 0) begin failures++; $display("FAIL ready_model bad_cycles=%0d exp=0", ready_err); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time=%0t exp=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
